// File: rtl/tcp_send_sched.sv
// tcp_send_sched: per-flow round-robin transmit scheduler for the TCP slow path.
// Picks a pending flow, reads its send-buffer pointers and peer window, issues one
// window/MSS-limited send command and writes back the advanced next_send_ptr.
// Optional feature macro: TCP_SEND_SCHED_ALIGN32_EN (trim segment length to 32B multiples).
module tcp_send_sched #(
    parameter int unsigned FLOWID_W     = 3,
    parameter int unsigned ptr_w        = 15,
    parameter int unsigned WIN_SIZE_W   = 16,
    parameter int unsigned MAX_SEG_SIZE = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  notify_val,
    input  logic [FLOWID_W-1:0]   notify_flowid,
    output logic                  notify_rdy,

    output logic                  st_rd_req_val,
    output logic [FLOWID_W-1:0]   st_rd_req_flowid,
    input  logic                  st_rd_req_rdy,

    input  logic                  st_rd_resp_val,
    output logic                  st_rd_resp_rdy,
    input  logic [ptr_w:0]        st_rd_resp_trail_ptr,
    input  logic [ptr_w:0]        st_rd_resp_lead_ptr,
    input  logic [ptr_w:0]        st_rd_resp_next_send_ptr,
    input  logic [WIN_SIZE_W-1:0] st_rd_resp_curr_win,

    output logic                  send_val,
    input  logic                  send_rdy,
    output logic [FLOWID_W-1:0]   send_flowid,
    output logic [ptr_w:0]        send_ptr,
    output logic [ptr_w:0]        send_len,

    output logic                  nsp_wr_val,
    output logic [FLOWID_W-1:0]   nsp_wr_flowid,
    output logic [ptr_w:0]        nsp_wr_ptr
);

    localparam int unsigned NFLOW = 2**FLOWID_W;
    localparam int unsigned PW    = ptr_w + 1;
    localparam int unsigned CW    = (PW > WIN_SIZE_W) ? PW : WIN_SIZE_W;

    typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_RESP, S_CALC, S_SEND} state_t;

    state_t                state, state_nxt;
    logic [NFLOW-1:0]      pending, pending_d, set_mask, clr_mask;
    logic [FLOWID_W-1:0]   last_flow, cur_flow, pick_flow, pick_idx;
    logic                  pick_found;
    logic                  renotify;
    logic                  rem_zero;
    logic [PW-1:0]         trail_q, lead_q, nsp_q;
    logic [WIN_SIZE_W-1:0] win_q;
    logic [PW-1:0]         unsent, unacked, seg_len;
    logic [CW-1:0]         avail, max_len;
    logic                  st_rd_req_val_d, st_rd_resp_rdy_d, send_val_d;

    assign notify_rdy = 1'b1;

    // The write-back strobe must coincide with the send accept, which depends on send_rdy
    // in that same cycle; it is the registered send_val qualified by the handshake.
    assign nsp_wr_val = send_val & send_rdy;

    // Round-robin pick: first pending flow searching upward from last_flow+1, wrapping
    always_comb begin
        pick_found = 1'b0;
        pick_flow  = '0;
        pick_idx   = '0;
        for (int unsigned i = 1; i <= NFLOW; i++) begin
            pick_idx = last_flow + FLOWID_W'(i);
            if (!pick_found && pending[pick_idx]) begin
                pick_found = 1'b1;
                pick_flow  = pick_idx;
            end
        end
    end

    // Segment length: window- and MSS-limited, modulo pointer arithmetic
    always_comb begin
        unsent  = lead_q - nsp_q;
        unacked = nsp_q - trail_q;
        avail   = (CW'(win_q) < CW'(unacked)) ? '0 : CW'(win_q) - CW'(unacked);
        max_len = (avail < CW'(MAX_SEG_SIZE)) ? avail : CW'(MAX_SEG_SIZE);
        if (CW'(unsent) > max_len) begin
            seg_len = PW'(max_len);
`ifdef TCP_SEND_SCHED_ALIGN32_EN
        end else if (unsent < PW'(32)) begin
            seg_len = unsent;
        end else begin
            seg_len = unsent & ~PW'(31);
        end
`else
        end else begin
            seg_len = unsent;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (pick_found)     state_nxt = S_RD_REQ;
            S_RD_REQ:  if (st_rd_req_rdy)  state_nxt = S_RD_RESP;
            S_RD_RESP: if (st_rd_resp_val) state_nxt = S_CALC;
            S_CALC:    state_nxt = (seg_len == '0) ? S_IDLE : S_SEND;
            S_SEND:    if (send_rdy)       state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Output / bitmap next values; a notify seen during service keeps the bit set
    always_comb begin
        st_rd_req_val_d  = (state_nxt == S_RD_REQ);
        st_rd_resp_rdy_d = (state_nxt == S_RD_RESP);
        send_val_d       = (state_nxt == S_SEND);
        set_mask = '0;
        clr_mask = '0;
        if (notify_val) set_mask[notify_flowid] = 1'b1;
        if (state == S_CALC && seg_len == '0 && !renotify) clr_mask[cur_flow] = 1'b1;
        if (state == S_SEND && send_rdy && rem_zero && !renotify) clr_mask[cur_flow] = 1'b1;
        pending_d = (pending & ~clr_mask) | set_mask;
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending          <= '0;
            last_flow        <= '1;
            cur_flow         <= '0;
            renotify         <= 1'b0;
            rem_zero         <= 1'b0;
            trail_q          <= '0;
            lead_q           <= '0;
            nsp_q            <= '0;
            win_q            <= '0;
            st_rd_req_val    <= 1'b0;
            st_rd_req_flowid <= '0;
            st_rd_resp_rdy   <= 1'b0;
            send_val         <= 1'b0;
            send_flowid      <= '0;
            send_ptr         <= '0;
            send_len         <= '0;
            nsp_wr_flowid    <= '0;
            nsp_wr_ptr       <= '0;
        end else begin
            pending        <= pending_d;
            st_rd_req_val  <= st_rd_req_val_d;
            st_rd_resp_rdy <= st_rd_resp_rdy_d;
            send_val       <= send_val_d;
            renotify       <= (state == S_IDLE) ? 1'b0
                            : (renotify | (notify_val && notify_flowid == cur_flow));
            if (state == S_IDLE && pick_found) begin
                cur_flow         <= pick_flow;
                st_rd_req_flowid <= pick_flow;
            end
            if (state == S_RD_RESP && st_rd_resp_val) begin
                trail_q <= st_rd_resp_trail_ptr;
                lead_q  <= st_rd_resp_lead_ptr;
                nsp_q   <= st_rd_resp_next_send_ptr;
                win_q   <= st_rd_resp_curr_win;
            end
            if (state == S_CALC) begin
                if (seg_len == '0) begin
                    last_flow <= cur_flow;
                end else begin
                    send_flowid   <= cur_flow;
                    send_ptr      <= nsp_q;
                    send_len      <= seg_len;
                    nsp_wr_flowid <= cur_flow;
                    nsp_wr_ptr    <= nsp_q + seg_len;
                    rem_zero      <= (unsent == seg_len);
                end
            end
            if (state == S_SEND && send_rdy) last_flow <= cur_flow;
        end
    end

endmodule

// File: tb/tb_tcp_send_sched.sv
// Testbench for tcp_send_sched: flow-state responder model, scoreboard of expected
// send commands, and directed scenarios with hand-computed segment lengths.
module tb_tcp_send_sched;

    localparam int unsigned FW = 3;
    localparam int unsigned PW = 16;
    localparam int unsigned WW = 16;

    typedef struct packed {
        logic [FW-1:0] f;
        logic [PW-1:0] ptr;
        logic [PW-1:0] len;
        logic [PW-1:0] nxt;
    } exp_t;

    logic          clk, rst_n;
    logic          notify_val, notify_rdy;
    logic [FW-1:0] notify_flowid;
    logic          st_rd_req_val, st_rd_req_rdy;
    logic [FW-1:0] st_rd_req_flowid;
    logic          st_rd_resp_val, st_rd_resp_rdy;
    logic [PW-1:0] st_rd_resp_trail_ptr, st_rd_resp_lead_ptr, st_rd_resp_next_send_ptr;
    logic [WW-1:0] st_rd_resp_curr_win;
    logic          send_val, send_rdy;
    logic [FW-1:0] send_flowid;
    logic [PW-1:0] send_ptr, send_len;
    logic          nsp_wr_val;
    logic [FW-1:0] nsp_wr_flowid;
    logic [PW-1:0] nsp_wr_ptr;

    int   n_vec = 0;
    int   n_err = 0;
    int   rd_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;

    logic [PW-1:0] m_trail[8];
    logic [PW-1:0] m_lead[8];
    logic [PW-1:0] m_nsp[8];
    logic [WW-1:0] m_win[8];

    tcp_send_sched dut (
        .clk(clk), .rst_n(rst_n),
        .notify_val(notify_val), .notify_flowid(notify_flowid), .notify_rdy(notify_rdy),
        .st_rd_req_val(st_rd_req_val), .st_rd_req_flowid(st_rd_req_flowid),
        .st_rd_req_rdy(st_rd_req_rdy),
        .st_rd_resp_val(st_rd_resp_val), .st_rd_resp_rdy(st_rd_resp_rdy),
        .st_rd_resp_trail_ptr(st_rd_resp_trail_ptr), .st_rd_resp_lead_ptr(st_rd_resp_lead_ptr),
        .st_rd_resp_next_send_ptr(st_rd_resp_next_send_ptr),
        .st_rd_resp_curr_win(st_rd_resp_curr_win),
        .send_val(send_val), .send_rdy(send_rdy), .send_flowid(send_flowid),
        .send_ptr(send_ptr), .send_len(send_len),
        .nsp_wr_val(nsp_wr_val), .nsp_wr_flowid(nsp_wr_flowid), .nsp_wr_ptr(nsp_wr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic set_flow(input int f, input logic [PW-1:0] tr, input logic [PW-1:0] ns,
                            input logic [PW-1:0] ld, input logic [WW-1:0] w);
        m_trail[f] = tr; m_nsp[f] = ns; m_lead[f] = ld; m_win[f] = w;
    endtask

    task automatic exp_push(input int f, input logic [PW-1:0] p, input logic [PW-1:0] l,
                            input logic [PW-1:0] n);
        exp_t e;
        e.f = FW'(f); e.ptr = p; e.len = l; e.nxt = n;
        sb.push_back(e);
    endtask

    task automatic notify(input int f);
        @(posedge clk); #1;
        notify_val = 1'b1; notify_flowid = FW'(f);
        @(posedge clk); #1;
        notify_val = 1'b0;
    endtask

    // Wait for all expected sends, let the scheduler settle, then check read count
    task automatic drain(input string nm, input int rd0, input int exp_rd);
        int t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: %0d sends outstanding, expected 0", nm, sb.size());
            sb.delete();
        end
        repeat (25) @(posedge clk);
        #1;
        check({nm, "_reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
    endtask

    // Flow-state memory responder: answers each accepted read on the next cycle
    initial begin : responder
        logic          acc_req, acc_resp;
        logic [FW-1:0] rf;
        st_rd_resp_val = 1'b0;
        st_rd_resp_trail_ptr = '0; st_rd_resp_lead_ptr = '0;
        st_rd_resp_next_send_ptr = '0; st_rd_resp_curr_win = '0;
        forever begin
            @(negedge clk);
            acc_req  = rst_n && st_rd_req_val && st_rd_req_rdy;
            acc_resp = rst_n && st_rd_resp_val && st_rd_resp_rdy;
            rf       = st_rd_req_flowid;
            @(posedge clk); #1;
            if (acc_resp || !rst_n) st_rd_resp_val = 1'b0;
            if (acc_req && rst_n) begin
                st_rd_resp_trail_ptr     = m_trail[rf];
                st_rd_resp_lead_ptr      = m_lead[rf];
                st_rd_resp_next_send_ptr = m_nsp[rf];
                st_rd_resp_curr_win      = m_win[rf];
                st_rd_resp_val           = 1'b1;
                rd_cnt++;
            end
        end
    end

    // Monitor: compare each accepted send command against the scoreboard
    always @(negedge clk) begin
        if (rst_n && send_val && send_rdy) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_send: flow %0d ptr 0x%0h len %0d, expected no send",
                         send_flowid, send_ptr, send_len);
            end else begin
                mon_e = sb.pop_front();
                check("send_flowid",   32'(send_flowid),   32'(mon_e.f));
                check("send_ptr",      32'(send_ptr),      32'(mon_e.ptr));
                check("send_len",      32'(send_len),      32'(mon_e.len));
                check("nsp_wr_val",    32'(nsp_wr_val),    32'd1);
                check("nsp_wr_flowid", 32'(nsp_wr_flowid), 32'(mon_e.f));
                check("nsp_wr_ptr",    32'(nsp_wr_ptr),    32'(mon_e.nxt));
                m_nsp[mon_e.f] = mon_e.nxt;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int rd0;
        int t;
        rst_n = 1'b1; notify_val = 1'b0; notify_flowid = '0;
        st_rd_req_rdy = 1'b1; send_rdy = 1'b1;
        for (int i = 0; i < 8; i++) set_flow(i, '0, '0, '0, '0);
        #2 rst_n = 1'b0;
        #10;
        check("rst_req_val",    32'(st_rd_req_val),  32'd0);
        check("rst_resp_rdy",   32'(st_rd_resp_rdy), 32'd0);
        check("rst_send_val",   32'(send_val),       32'd0);
        check("rst_nsp_wr_val", 32'(nsp_wr_val),     32'd0);
        check("rst_send_len",   32'(send_len),       32'd0);
        check("rst_notify_rdy", 32'(notify_rdy),     32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Flow 2: 100 bytes unsent, wide window
        rd0 = rd_cnt;
        set_flow(2, 16'd0, 16'd0, 16'd100, 16'd4096);
`ifdef TCP_SEND_SCHED_ALIGN32_EN
        exp_push(2, 16'd0, 16'd96, 16'd96);
        exp_push(2, 16'd96, 16'd4, 16'd100);
        notify(2);
        drain("flow2", rd0, 2);
`else
        exp_push(2, 16'd0, 16'd100, 16'd100);
        notify(2);
        drain("flow2", rd0, 1);
`endif

        // Flow 0: 3000 bytes, MSS-limited segments
        rd0 = rd_cnt;
        set_flow(0, 16'd0, 16'd0, 16'd3000, 16'd4096);
        exp_push(0, 16'd0,    16'd1024, 16'd1024);
        exp_push(0, 16'd1024, 16'd1024, 16'd2048);
`ifdef TCP_SEND_SCHED_ALIGN32_EN
        exp_push(0, 16'd2048, 16'd928, 16'd2976);
        exp_push(0, 16'd2976, 16'd24,  16'd3000);
        notify(0);
        drain("flow0", rd0, 4);
`else
        exp_push(0, 16'd2048, 16'd952, 16'd3000);
        notify(0);
        drain("flow0", rd0, 3);
`endif

        // Window limit: 100 bytes of window left, then window exhausted
        rd0 = rd_cnt;
        set_flow(3, 16'd0, 16'd900, 16'd2000, 16'd1000);
        exp_push(3, 16'd900, 16'd100, 16'd1000);
        notify(3);
        drain("win100", rd0, 2);

        // Peer window smaller than unacked data: no send, bit cleared
        rd0 = rd_cnt;
        set_flow(4, 16'd0, 16'd900, 16'd2000, 16'd800);
        notify(4);
        drain("win0", rd0, 1);

        // Pointer wrap-around
        rd0 = rd_cnt;
        set_flow(7, 16'hFFF0, 16'hFFF0, 16'h0010, 16'd4096);
        exp_push(7, 16'hFFF0, 16'd32, 16'h0010);
        notify(7);
        drain("wrap", rd0, 1);

        // Round robin across flows 1, 5, 6
        rd0 = rd_cnt;
        set_flow(1, 16'd0, 16'd0, 16'd64,  16'd4096);
        set_flow(5, 16'd0, 16'd0, 16'd128, 16'd4096);
        set_flow(6, 16'd0, 16'd0, 16'd256, 16'd4096);
        exp_push(1, 16'd0, 16'd64,  16'd64);
        exp_push(5, 16'd0, 16'd128, 16'd128);
        exp_push(6, 16'd0, 16'd256, 16'd256);
        notify(1); notify(5); notify(6);
        drain("rr", rd0, 3);

        // Round robin with flow 1 re-notified while flow 5 is in service
        rd0 = rd_cnt;
        set_flow(1, 16'd0, 16'd0, 16'd32, 16'd4096);
        set_flow(5, 16'd0, 16'd0, 16'd64, 16'd4096);
        set_flow(6, 16'd0, 16'd0, 16'd96, 16'd4096);
        exp_push(1, 16'd0, 16'd32, 16'd32);
        exp_push(5, 16'd0, 16'd64, 16'd64);
        exp_push(6, 16'd0, 16'd96, 16'd96);
        exp_push(1, 16'd32, 16'd160, 16'd192);
        notify(1); notify(5); notify(6);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(st_rd_req_val && st_rd_req_flowid == FW'(5)) && t < 300);
        check("rr2_wait_flow5", 32'(t < 300), 32'd1);
        m_lead[1] = 16'd192;
        notify(1);
        drain("rr2", rd0, 4);

        // Back-pressure on send, with a re-notify of the in-service flow
        rd0 = rd_cnt;
        set_flow(4, 16'd0, 16'd0, 16'd512, 16'd4096);
        exp_push(4, 16'd0, 16'd512, 16'd512);
        exp_push(4, 16'd512, 16'd64, 16'd576);
        @(posedge clk); #1;
        send_rdy = 1'b0;
        notify(4);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!send_val && t < 300);
        check("stall_wait_send", 32'(t < 300), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_send_val", 32'(send_val),    32'd1);
            check("stall_flowid",   32'(send_flowid), 32'd4);
            check("stall_ptr",      32'(send_ptr),    32'd0);
            check("stall_len",      32'(send_len),    32'd512);
            check("stall_nsp_wr",   32'(nsp_wr_val),  32'd0);
            if (i == 3) begin
                m_lead[4] = 16'd576;
                notify_val = 1'b1; notify_flowid = FW'(4);
            end
            if (i == 4) notify_val = 1'b0;
        end
        @(posedge clk); #1;
        send_rdy = 1'b1;
        drain("stall", rd0, 2);

        // Reset while a send command is pending, with another flow queued
        set_flow(3, 16'd0, 16'd0, 16'd256, 16'd4096);
        set_flow(6, 16'd96, 16'd96, 16'd128, 16'd4096);
        @(posedge clk); #1;
        send_rdy = 1'b0;
        notify(3); notify(6);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!send_val && t < 300);
        check("rst_wait_send", 32'(t < 300), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_send_val", 32'(send_val),      32'd0);
        check("midrst_req_val",  32'(st_rd_req_val), 32'd0);
        check("midrst_nsp_wr",   32'(nsp_wr_val),    32'd0);
        check("midrst_send_len", 32'(send_len),      32'd0);
        #20;
        rst_n = 1'b1;
        send_rdy = 1'b1;
        rd0 = rd_cnt;
        repeat (30) @(posedge clk);
        #1;
        check("postrst_reads",    32'(rd_cnt - rd0), 32'd0);
        check("postrst_send_val", 32'(send_val),     32'd0);

        // Service resumes on a fresh notify
        rd0 = rd_cnt;
        set_flow(0, 16'd0, 16'd0, 16'd32, 16'd4096);
        exp_push(0, 16'd0, 16'd32, 16'd32);
        notify(0);
        drain("resume", rd0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
